// File: rtl/seg_scan_pkg.sv
// Shared types and glyph table for the multiplexed 7-segment scan controller.
// Segments are active-low, ordered {g,f,e,d,c,b,a}.
package seg_scan_pkg;

  typedef enum logic [0:0] {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } seg_state_e;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Indexed by nibble value; element 15 is listed first.
  localparam logic [15:0][6:0] SEG_GLYPH = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,  // F E d C b A 9 8
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40   // 7 6 5 4 3 2 1 0
  };

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    return SEG_GLYPH[nibble];
  endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// Slot cycle counter and digit index for the scan controller; flags the last
// cycle of each slot and the last cycle of the frame.
module seg_scan_timer #(
  parameter  int NDIG     = 8,
  parameter  int SLOT_CYC = 100000,
  localparam int CW       = $clog2(SLOT_CYC),
  localparam int IW       = $clog2(NDIG)
) (
  input  logic          clk,
  input  logic          rst,
  output logic [CW-1:0] cnt,
  output logic [IW-1:0] idx,
  output logic          slot_last,
  output logic          frame_tick
);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          idx_last;

  assign slot_last  = (cnt_q == CW'(SLOT_CYC - 1));
  assign idx_last   = (idx_q == IW'(NDIG - 1));
  assign frame_tick = slot_last & idx_last;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    idx_d = idx_q;
    if (slot_last) begin
      cnt_d = '0;
      idx_d = idx_last ? '0 : idx_q + IW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

  assign cnt = cnt_q;
  assign idx = idx_q;

endmodule

// File: rtl/seg_scan_ctrl.sv
// Refresh scheduler for a multiplexed common-anode 7-segment display with a
// frame-synchronous digit update handshake. Define SEG_SCAN_BLINK_EN for per-digit blink.
module seg_scan_ctrl
  import seg_scan_pkg::*;
#(
  parameter int NDIG         = 8,
  parameter int SLOT_CYC     = 100000,
  parameter int BLANK_CYC    = 1000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              upd_valid,
  output logic              upd_ready,
  input  logic [4*NDIG-1:0] upd_digits,
  input  logic [NDIG-1:0]   digit_mask,
`ifdef SEG_SCAN_BLINK_EN
  input  logic [NDIG-1:0]   blink_mask,
`endif
  output logic [NDIG-1:0]   anode,
  output logic [6:0]        segment,
  output logic              frame_tick
);

  localparam int CW = $clog2(SLOT_CYC);
  localparam int IW = $clog2(NDIG);

  if (NDIG < 2 || NDIG > 8 || BLANK_CYC < 1 || BLANK_CYC >= SLOT_CYC || BLINK_FRAMES < 1)
  begin : g_param_err
    $error("seg_scan_ctrl: parameter out of range");
  end

  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic          slot_last;
  logic          slot_start;

  seg_scan_timer #(
    .NDIG     (NDIG),
    .SLOT_CYC (SLOT_CYC)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .cnt        (cnt),
    .idx        (idx),
    .slot_last  (slot_last),
    .frame_tick (frame_tick)
  );

  assign slot_start = (cnt == '0);

  // Slot FSM
  seg_state_e state_q, state_d;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_BLANK: if (cnt == CW'(BLANK_CYC - 1)) state_d = ST_DRIVE;
      ST_DRIVE: if (slot_last)                 state_d = ST_BLANK;
      default:                                 state_d = ST_BLANK;
    endcase
  end

  // Blink phase
  logic blink_on;
`ifdef SEG_SCAN_BLINK_EN
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_on_q, blink_on_d;

  always_comb begin
    blink_cnt_d = blink_cnt_q;
    blink_on_d  = blink_on_q;
    if (frame_tick) begin
      if (blink_cnt_q == BW'(BLINK_FRAMES - 1)) begin
        blink_cnt_d = '0;
        blink_on_d  = ~blink_on_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b1;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      blink_on_q  <= blink_on_d;
    end
  end

  assign blink_on = blink_on_q | ~blink_mask[idx];
`else
  assign blink_on = 1'b1;
`endif

  // Digit enable is latched once per slot so mask changes never cut a slot short.
  logic digit_en_q, digit_en_d;

  always_comb begin
    digit_en_d = digit_en_q;
    if (slot_start) digit_en_d = digit_mask[idx] & blink_on;
  end

  // Update handshake: one staging word, promoted to active only at frame_tick.
  logic [4*NDIG-1:0] staging_q, staging_d;
  logic [4*NDIG-1:0] active_q, active_d;
  logic              pending_q, pending_d;

  assign upd_ready = ~pending_q;

  always_comb begin
    staging_d = staging_q;
    active_d  = active_q;
    pending_d = pending_q;
    if (pending_q) begin
      if (frame_tick) begin
        active_d  = staging_q;
        pending_d = 1'b0;
      end
    end else if (upd_valid) begin
      staging_d = upd_digits;
      pending_d = 1'b1;
    end
  end

  // Output stage
  logic [3:0]      nibble;
  logic [NDIG-1:0] anode_q, anode_d;
  logic [6:0]      segment_q, segment_d;

  always_comb begin
    nibble = 4'h0;
    for (int i = 0; i < NDIG; i++) begin
      if (idx == IW'(i)) nibble = active_q[4*i +: 4];
    end
  end

  always_comb begin
    anode_d   = '1;
    segment_d = SEG_OFF;
    if (state_q == ST_DRIVE && digit_en_q) begin
      anode_d   = ~(NDIG'(1) << idx);
      segment_d = hex_to_seg(nibble);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_BLANK;
      digit_en_q <= 1'b0;
      staging_q  <= '0;
      active_q   <= '0;
      pending_q  <= 1'b0;
      anode_q    <= '1;
      segment_q  <= SEG_OFF;
    end else begin
      state_q    <= state_d;
      digit_en_q <= digit_en_d;
      staging_q  <= staging_d;
      active_q   <= active_d;
      pending_q  <= pending_d;
      anode_q    <= anode_d;
      segment_q  <= segment_d;
    end
  end

  assign anode   = anode_q;
  assign segment = segment_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: directed scenarios plus random traffic
// checked every cycle against a frame/slot arithmetic model.
module tb_seg_scan_ctrl;

  localparam int NDIG         = 4;
  localparam int SLOT_CYC     = 8;
  localparam int BLANK_CYC    = 2;
  localparam int BLINK_FRAMES = 2;
  localparam int FRAME        = NDIG * SLOT_CYC;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        upd_valid = 1'b0;
  logic        upd_ready;
  logic [15:0] upd_digits = '0;
  logic [3:0]  digit_mask = '0;
`ifdef SEG_SCAN_BLINK_EN
  logic [3:0]  blink_mask = '0;
`endif
  logic [3:0]  anode;
  logic [6:0]  segment;
  logic        frame_tick;

  always #5 clk = ~clk;

  seg_scan_ctrl #(
    .NDIG         (NDIG),
    .SLOT_CYC     (SLOT_CYC),
    .BLANK_CYC    (BLANK_CYC),
    .BLINK_FRAMES (BLINK_FRAMES)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .upd_valid  (upd_valid),
    .upd_ready  (upd_ready),
    .upd_digits (upd_digits),
    .digit_mask (digit_mask),
`ifdef SEG_SCAN_BLINK_EN
    .blink_mask (blink_mask),
`endif
    .anode      (anode),
    .segment    (segment),
    .frame_tick (frame_tick)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  int          m_n;
  bit          m_pend;
  logic [15:0] m_stage, m_active;
  bit   [3:0]  m_en;
  logic [3:0]  m_exp_anode;
  logic [6:0]  m_exp_seg;

  // Stimulus the source wants to apply next cycle
  bit          drv_valid;
  logic [15:0] drv_digits;
  logic [3:0]  drv_mask;
  logic [3:0]  drv_blink;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, m_n);
    end
  endtask

  // Standard active-high gfedcba patterns, inverted for the common-anode pins.
  function automatic logic [6:0] glyph(input logic [3:0] h);
    logic [6:0] on;
    case (h)
      4'h0: on = 7'b0111111;  4'h1: on = 7'b0000110;
      4'h2: on = 7'b1011011;  4'h3: on = 7'b1001111;
      4'h4: on = 7'b1100110;  4'h5: on = 7'b1101101;
      4'h6: on = 7'b1111101;  4'h7: on = 7'b0000111;
      4'h8: on = 7'b1111111;  4'h9: on = 7'b1101111;
      4'hA: on = 7'b1110111;  4'hB: on = 7'b1111100;
      4'hC: on = 7'b0111001;  4'hD: on = 7'b1011110;
      4'hE: on = 7'b1111001;  default: on = 7'b1110001;
    endcase
    return ~on;
  endfunction

  task automatic model_reset();
    m_n         = 0;
    m_pend      = 1'b0;
    m_stage     = '0;
    m_active    = '0;
    m_en        = '0;
    m_exp_anode = 4'hF;
    m_exp_seg   = 7'h7F;
  endtask

  // One clock cycle: compare outputs for cycle m_n, apply inputs, advance the model.
  task automatic step();
    int p, slot, c;
    bit tick, en, acc;
    @(negedge clk);
    p    = m_n % FRAME;
    slot = p / SLOT_CYC;
    c    = p % SLOT_CYC;
    tick = (p == FRAME - 1);
    check_eq("anode", 32'(anode), 32'(m_exp_anode));
    check_eq("segment", 32'(segment), 32'(m_exp_seg));
    check_eq("upd_ready", 32'(upd_ready), 32'(!m_pend));
    check_eq("frame_tick", 32'(frame_tick), 32'(tick));

    upd_valid  = drv_valid;
    upd_digits = drv_digits;
    digit_mask = drv_mask;
`ifdef SEG_SCAN_BLINK_EN
    blink_mask = drv_blink;
`endif

    if (c == 0) begin
      en = drv_mask[slot];
`ifdef SEG_SCAN_BLINK_EN
      if (((m_n / FRAME) / BLINK_FRAMES) % 2 == 1 && drv_blink[slot]) en = 1'b0;
`endif
      m_en[slot] = en;
    end
    if (c >= BLANK_CYC && m_en[slot]) begin
      m_exp_anode = ~(4'b0001 << slot);
      m_exp_seg   = glyph(m_active[slot*4 +: 4]);
    end else begin
      m_exp_anode = 4'hF;
      m_exp_seg   = 7'h7F;
    end

    acc = drv_valid && !m_pend;
    if (m_pend && tick) begin
      m_active = m_stage;
      m_pend   = 1'b0;
    end else if (acc) begin
      m_stage = drv_digits;
      m_pend  = 1'b1;
    end
    if (acc) drv_valid = 1'b0;
    m_n++;
  endtask

  initial begin
    bit found;
    drv_valid  = 1'b0;
    drv_digits = '0;
    drv_mask   = '0;
    drv_blink  = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Full mask, 1234 offered at cycle 0
    drv_mask   = 4'hF;
    drv_digits = 16'h1234;
    drv_valid  = 1'b1;
    repeat (3 * FRAME) step();

    // Mid-frame update, then a second word while the first is pending
    repeat (10) step();
    drv_digits = 16'h0042;
    drv_valid  = 1'b1;
    repeat (5) step();
    drv_digits = 16'h9999;
    drv_valid  = 1'b1;
    repeat (3 * FRAME) step();

    // Partial mask keeps the frame period
    drv_mask = 4'b0101;
    repeat (2 * FRAME) step();

`ifdef SEG_SCAN_BLINK_EN
    drv_mask  = 4'hF;
    drv_blink = 4'b0001;
    repeat (6 * FRAME) step();
    drv_blink = '0;
`endif

    // Random traffic
    repeat (20 * FRAME) begin
      if (!drv_valid && $urandom_range(0, 15) == 0) begin
        drv_valid  = 1'b1;
        drv_digits = 16'($urandom);
      end
      if ($urandom_range(0, 63) == 0) drv_mask = 4'($urandom);
`ifdef SEG_SCAN_BLINK_EN
      if ($urandom_range(0, 63) == 0) drv_blink = 4'($urandom);
`endif
      step();
    end

    // Asynchronous reset in the middle of a driven slot with a word pending
    drv_mask   = 4'hF;
    drv_digits = 16'hABCD;
    drv_valid  = 1'b1;
    found      = 1'b0;
    for (int i = 0; i < 3 * FRAME && !found; i++) begin
      step();
      if (m_pend && (m_n % SLOT_CYC) == 5) found = 1'b1;
    end
    check_eq("rst_setup", 32'(found), 32'd1);
    if (found) begin
      @(posedge clk);
      #2;
      check_eq("pre_rst_anode", 32'(anode), 32'(m_exp_anode));
      rst = 1'b1;
      #1;
      check_eq("rst_anode", 32'(anode), 32'hF);
      check_eq("rst_segment", 32'(segment), 32'h7F);
      check_eq("rst_upd_ready", 32'(upd_ready), 32'd1);
      check_eq("rst_frame_tick", 32'(frame_tick), 32'd0);
      drv_valid = 1'b0;
      upd_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      model_reset();
      repeat (2 * FRAME) step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
